// File: rtl/id_ex_pipeline_reg.sv
// Decode->Execute pipeline register with load-use hazard detection.
// Optional bubble counter output enabled by defining ID_EX_BUBBLE_CNT_EN.
module id_ex_pipeline_reg #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            StallE,
   input  logic            FlushE,
   input  logic            ValidD,
   input  logic            RegWriteD,
   input  logic [2:0]      ResultSrcD,
   input  logic            MemWriteD,
   input  logic            BranchD,
   input  logic            ALUSrcD,
   input  logic [1:0]      JumpD,
   input  logic [1:0]      ALUOpD,
   input  logic [XLEN-1:0] PCD,
   input  logic [XLEN-1:0] PCPlus4D,
   input  logic [XLEN-1:0] RD1D,
   input  logic [XLEN-1:0] RD2D,
   input  logic [XLEN-1:0] ImmExtD,
   input  logic [4:0]      Rs1D,
   input  logic [4:0]      Rs2D,
   input  logic [4:0]      RdD,
   input  logic [2:0]      Funct3D,
   input  logic [11:0]     CsrAddrD,
   output logic            ValidE,
   output logic            RegWriteE,
   output logic [2:0]      ResultSrcE,
   output logic            MemWriteE,
   output logic            BranchE,
   output logic            ALUSrcE,
   output logic [1:0]      JumpE,
   output logic [1:0]      ALUOpE,
   output logic [XLEN-1:0] PCE,
   output logic [XLEN-1:0] PCPlus4E,
   output logic [XLEN-1:0] RD1E,
   output logic [XLEN-1:0] RD2E,
   output logic [XLEN-1:0] ImmExtE,
   output logic [4:0]      Rs1E,
   output logic [4:0]      Rs2E,
   output logic [4:0]      RdE,
   output logic [2:0]      Funct3E,
   output logic [11:0]     CsrAddrE,
`ifdef ID_EX_BUBBLE_CNT_EN
   output logic [31:0]     BubbleCntE,
`endif
   output logic            LoadUseStall
);

   localparam logic [2:0] RESULT_MEM = 3'b001;

   logic bubble;

   // Rs2D is compared even when the D instruction has no rs2; a spurious stall is harmless.
   assign LoadUseStall = ValidE & ValidD & RegWriteE & (ResultSrcE == RESULT_MEM) &
                         (RdE != 5'd0) & ((Rs1D == RdE) | (Rs2D == RdE));

   assign bubble = FlushE | LoadUseStall;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ValidE     <= 1'b0;
         RegWriteE  <= 1'b0;
         ResultSrcE <= 3'b000;
         MemWriteE  <= 1'b0;
         BranchE    <= 1'b0;
         ALUSrcE    <= 1'b0;
         JumpE      <= 2'b00;
         ALUOpE     <= 2'b00;
         PCE        <= '0;
         PCPlus4E   <= '0;
         RD1E       <= '0;
         RD2E       <= '0;
         ImmExtE    <= '0;
         Rs1E       <= 5'd0;
         Rs2E       <= 5'd0;
         RdE        <= 5'd0;
         Funct3E    <= 3'b000;
         CsrAddrE   <= 12'd0;
      end else if (bubble) begin
         ValidE     <= 1'b0;
         RegWriteE  <= 1'b0;
         ResultSrcE <= 3'b000;
         MemWriteE  <= 1'b0;
         BranchE    <= 1'b0;
         ALUSrcE    <= 1'b0;
         JumpE      <= 2'b00;
         ALUOpE     <= 2'b00;
         PCE        <= '0;
         PCPlus4E   <= '0;
         RD1E       <= '0;
         RD2E       <= '0;
         ImmExtE    <= '0;
         Rs1E       <= 5'd0;
         Rs2E       <= 5'd0;
         RdE        <= 5'd0;
         Funct3E    <= 3'b000;
         CsrAddrE   <= 12'd0;
      end else if (!StallE) begin
         ValidE     <= ValidD;
         RegWriteE  <= RegWriteD;
         ResultSrcE <= ResultSrcD;
         MemWriteE  <= MemWriteD;
         BranchE    <= BranchD;
         ALUSrcE    <= ALUSrcD;
         JumpE      <= JumpD;
         ALUOpE     <= ALUOpD;
         PCE        <= PCD;
         PCPlus4E   <= PCPlus4D;
         RD1E       <= RD1D;
         RD2E       <= RD2D;
         ImmExtE    <= ImmExtD;
         Rs1E       <= Rs1D;
         Rs2E       <= Rs2D;
         RdE        <= RdD;
         Funct3E    <= Funct3D;
         CsrAddrE   <= CsrAddrD;
      end
   end

`ifdef ID_EX_BUBBLE_CNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         BubbleCntE <= 32'd0;
      end else if (bubble && (BubbleCntE != 32'hFFFF_FFFF)) begin
         BubbleCntE <= BubbleCntE + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_id_ex_pipeline_reg.sv
// Scoreboard bench for id_ex_pipeline_reg: per-cycle expected E contents queued and compared.
module tb_id_ex_pipeline_reg;

   typedef struct packed {
      logic        valid;
      logic        regWrite;
      logic [2:0]  resultSrc;
      logic        memWrite;
      logic        branch;
      logic        aluSrc;
      logic [1:0]  jump;
      logic [1:0]  aluOp;
      logic [31:0] pc;
      logic [31:0] pcPlus4;
      logic [31:0] rd1;
      logic [31:0] rd2;
      logic [31:0] imm;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic [2:0]  funct3;
      logic [11:0] csrAddr;
   } stageT;

   logic clk = 1'b0;
   logic rst_n;
   logic StallE, FlushE, ValidD, RegWriteD, MemWriteD, BranchD, ALUSrcD;
   logic [2:0] ResultSrcD, Funct3D;
   logic [1:0] JumpD, ALUOpD;
   logic [31:0] PCD, PCPlus4D, RD1D, RD2D, ImmExtD;
   logic [4:0] Rs1D, Rs2D, RdD;
   logic [11:0] CsrAddrD;
   logic ValidE, RegWriteE, MemWriteE, BranchE, ALUSrcE, LoadUseStall;
   logic [2:0] ResultSrcE, Funct3E;
   logic [1:0] JumpE, ALUOpE;
   logic [31:0] PCE, PCPlus4E, RD1E, RD2E, ImmExtE;
   logic [4:0] Rs1E, Rs2E, RdE;
   logic [11:0] CsrAddrE;
`ifdef ID_EX_BUBBLE_CNT_EN
   logic [31:0] BubbleCntE;
   logic [31:0] cntModel;
`endif

   stageT obsE;
   stageT modelE;
   stageT expQ[$];
   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   id_ex_pipeline_reg #(.XLEN(32)) dut (
      .clk(clk), .rst_n(rst_n), .StallE(StallE), .FlushE(FlushE),
      .ValidD(ValidD), .RegWriteD(RegWriteD), .ResultSrcD(ResultSrcD),
      .MemWriteD(MemWriteD), .BranchD(BranchD), .ALUSrcD(ALUSrcD),
      .JumpD(JumpD), .ALUOpD(ALUOpD), .PCD(PCD), .PCPlus4D(PCPlus4D),
      .RD1D(RD1D), .RD2D(RD2D), .ImmExtD(ImmExtD), .Rs1D(Rs1D), .Rs2D(Rs2D),
      .RdD(RdD), .Funct3D(Funct3D), .CsrAddrD(CsrAddrD),
      .ValidE(ValidE), .RegWriteE(RegWriteE), .ResultSrcE(ResultSrcE),
      .MemWriteE(MemWriteE), .BranchE(BranchE), .ALUSrcE(ALUSrcE),
      .JumpE(JumpE), .ALUOpE(ALUOpE), .PCE(PCE), .PCPlus4E(PCPlus4E),
      .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE), .Rs1E(Rs1E), .Rs2E(Rs2E),
      .RdE(RdE), .Funct3E(Funct3E), .CsrAddrE(CsrAddrE),
`ifdef ID_EX_BUBBLE_CNT_EN
      .BubbleCntE(BubbleCntE),
`endif
      .LoadUseStall(LoadUseStall)
   );

   assign obsE = {ValidE, RegWriteE, ResultSrcE, MemWriteE, BranchE, ALUSrcE, JumpE, ALUOpE,
                  PCE, PCPlus4E, RD1E, RD2E, ImmExtE, Rs1E, Rs2E, RdE, Funct3E, CsrAddrE};

   task automatic applyD(input stageT d);
      ValidD = d.valid; RegWriteD = d.regWrite; ResultSrcD = d.resultSrc;
      MemWriteD = d.memWrite; BranchD = d.branch; ALUSrcD = d.aluSrc;
      JumpD = d.jump; ALUOpD = d.aluOp; PCD = d.pc; PCPlus4D = d.pcPlus4;
      RD1D = d.rd1; RD2D = d.rd2; ImmExtD = d.imm; Rs1D = d.rs1; Rs2D = d.rs2;
      RdD = d.rd; Funct3D = d.funct3; CsrAddrD = d.csrAddr;
   endtask

   function automatic logic lusModel(input stageT e, input stageT d);
      return e.valid & d.valid & e.regWrite & (e.resultSrc == 3'b001) & (e.rd != 5'd0) &
             ((d.rs1 == e.rd) | (d.rs2 == e.rd));
   endfunction

   function automatic stageT mkInstr(input logic [2:0] resSrc, input logic regWr, input logic memWr,
                                     input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                                     input logic [31:0] pc);
      stageT s;
      s = '0;
      s.valid = 1'b1; s.regWrite = regWr; s.resultSrc = resSrc; s.memWrite = memWr;
      s.rs1 = rs1; s.rs2 = rs2; s.rd = rd; s.pc = pc; s.pcPlus4 = pc + 32'd4;
      s.rd1 = pc ^ 32'hA5A5_0000; s.rd2 = pc ^ 32'h0000_5A5A; s.funct3 = 3'b010;
      return s;
   endfunction

   // One clock: check the combinational stall before the edge, then the queued E contents after it.
   task automatic cycle(input stageT d, input logic stall, input logic flush, input logic expLus,
                        input string name);
      stageT nxt, want;
      @(negedge clk);
      applyD(d); StallE = stall; FlushE = flush;
      #1;
      total++;
      if (LoadUseStall !== expLus) begin
         bad++;
         $display("FAIL %s LoadUseStall got=%0b want=%0b", name, LoadUseStall, expLus);
      end
      if (flush | expLus) begin
         nxt = '0;
`ifdef ID_EX_BUBBLE_CNT_EN
         if (cntModel != 32'hFFFF_FFFF) cntModel = cntModel + 32'd1;
`endif
      end else if (stall) begin
         nxt = modelE;
      end else begin
         nxt = d;
      end
      expQ.push_back(nxt);
      @(posedge clk);
      #1;
      want = expQ.pop_front();
      modelE = nxt;
      total++;
      if (obsE !== want) begin
         bad++;
         $display("FAIL %s E-stage got=%h want=%h", name, obsE, want);
      end
`ifdef ID_EX_BUBBLE_CNT_EN
      total++;
      if (BubbleCntE !== cntModel) begin
         bad++;
         $display("FAIL %s BubbleCntE got=%0d want=%0d", name, BubbleCntE, cntModel);
      end
`endif
   endtask

   task automatic clearModel();
      modelE = '0;
`ifdef ID_EX_BUBBLE_CNT_EN
      cntModel = 32'd0;
`endif
   endtask

   task automatic test_reset();
      stageT ones, lw, use1;
      ones = '1;
      cycle(ones, 1'b0, 1'b0, 1'b0, "reset_preload");
      #3 rst_n = 1'b0;
      #1;
      total++;
      if (obsE !== '0 || LoadUseStall !== 1'b0) begin
         bad++;
         $display("FAIL reset_async E=%h lus=%0b want E=0 lus=0", obsE, LoadUseStall);
      end
      @(negedge clk) rst_n = 1'b1;
      clearModel();
      // reset while a load-use stall is being requested
      lw   = mkInstr(3'b001, 1'b1, 1'b0, 5'd2, 5'd0, 5'd9, 32'h200);
      use1 = mkInstr(3'b000, 1'b1, 1'b0, 5'd9, 5'd3, 5'd10, 32'h204);
      cycle(lw, 1'b0, 1'b0, 1'b0, "reset_stall_lw");
      @(negedge clk);
      applyD(use1);
      #1;
      total++;
      if (LoadUseStall !== 1'b1) begin
         bad++;
         $display("FAIL reset_stall_pre lus got=%0b want=1", LoadUseStall);
      end
      rst_n = 1'b0;
      #1;
      total++;
      if (LoadUseStall !== 1'b0 || obsE !== '0) begin
         bad++;
         $display("FAIL reset_stall_clear E=%h lus=%0b want E=0 lus=0", obsE, LoadUseStall);
      end
      @(negedge clk) rst_n = 1'b1;
      clearModel();
      cycle(use1, 1'b0, 1'b0, 1'b0, "reset_stall_release");
   endtask

   task automatic test_pass_through();
      stageT addi;
      addi = mkInstr(3'b000, 1'b1, 1'b0, 5'd1, 5'd0, 5'd5, 32'h100);
      addi.aluSrc = 1'b1; addi.aluOp = 2'b10; addi.imm = 32'd7; addi.funct3 = 3'b000;
      addi.csrAddr = 12'h007;
      cycle(addi, 1'b0, 1'b0, 1'b0, "pass_addi");
      total++;
      if (ValidE !== 1'b1 || RdE !== 5'd5 || ImmExtE !== 32'd7 || ALUOpE !== 2'b10) begin
         bad++;
         $display("FAIL pass_fields valid=%0b rd=%0d imm=%0d aluop=%b want 1/5/7/10",
                  ValidE, RdE, ImmExtE, ALUOpE);
      end
   endtask

   task automatic test_load_use();
      stageT lw, add, useFlush;
      lw  = mkInstr(3'b001, 1'b1, 1'b0, 5'd2, 5'd0, 5'd5, 32'h300);
      add = mkInstr(3'b000, 1'b1, 1'b0, 5'd5, 5'd1, 5'd6, 32'h304);
      cycle(lw, 1'b0, 1'b0, 1'b0, "lu_lw");
      cycle(add, 1'b0, 1'b0, 1'b1, "lu_bubble");
      cycle(add, 1'b0, 1'b0, 1'b0, "lu_add_enters");
      // match via rs2, with a concurrent flush: still one bubble
      useFlush = mkInstr(3'b000, 1'b1, 1'b0, 5'd3, 5'd5, 5'd7, 32'h30C);
      cycle(lw, 1'b0, 1'b0, 1'b0, "lu_lw2");
      cycle(useFlush, 1'b0, 1'b1, 1'b1, "lu_flush_rs2");
      cycle(useFlush, 1'b0, 1'b0, 1'b0, "lu_after_flush");
   endtask

   task automatic test_no_stall();
      stageT lwX0, csr, use0, use7, inv;
      lwX0 = mkInstr(3'b001, 1'b1, 1'b0, 5'd2, 5'd0, 5'd0, 32'h400);
      use0 = mkInstr(3'b000, 1'b1, 1'b0, 5'd0, 5'd0, 5'd4, 32'h404);
      cycle(lwX0, 1'b0, 1'b0, 1'b0, "ns_lw_x0");
      cycle(use0, 1'b0, 1'b0, 1'b0, "ns_x0_use");
      csr  = mkInstr(3'b100, 1'b1, 1'b0, 5'd0, 5'd0, 5'd7, 32'h408);
      use7 = mkInstr(3'b000, 1'b1, 1'b0, 5'd7, 5'd0, 5'd8, 32'h40C);
      cycle(csr, 1'b0, 1'b0, 1'b0, "ns_csr");
      cycle(use7, 1'b0, 1'b0, 1'b0, "ns_csr_use");
      // load followed by an invalid D slot that names the load's rd
      cycle(mkInstr(3'b001, 1'b1, 1'b0, 5'd1, 5'd0, 5'd7, 32'h410), 1'b0, 1'b0, 1'b0, "ns_lw7");
      inv = use7; inv.valid = 1'b0;
      cycle(inv, 1'b0, 1'b0, 1'b0, "ns_invalid_d");
   endtask

   task automatic test_flush_stall();
      stageT sw, b, other;
      sw = mkInstr(3'b000, 1'b0, 1'b1, 5'd2, 5'd3, 5'd0, 32'h500);
      b  = mkInstr(3'b010, 1'b1, 1'b0, 5'd4, 5'd0, 5'd1, 32'h504);
      b.jump = 2'b01; b.branch = 1'b1;
      cycle(b, 1'b0, 1'b0, 1'b0, "fs_prior");
      cycle(sw, 1'b1, 1'b1, 1'b0, "fs_flush_wins");
      total++;
      if (MemWriteE !== 1'b0 || ValidE !== 1'b0) begin
         bad++;
         $display("FAIL fs_memwrite got=%0b valid=%0b want 0/0", MemWriteE, ValidE);
      end
      cycle(b, 1'b0, 1'b0, 1'b0, "fs_capture");
      other = mkInstr(3'b011, 1'b1, 1'b1, 5'd9, 5'd9, 5'd9, 32'h5F0);
      for (int i = 0; i < 3; i++) cycle(other, 1'b1, 1'b0, 1'b0, "fs_hold");
      cycle(other, 1'b0, 1'b0, 1'b0, "fs_release");
   endtask

   task automatic test_back_to_back();
      stageT d;
      logic st, fl;
      for (int i = 0; i < 40; i++) begin
         d = '0;
         d.valid = 1'($urandom_range(0, 1)); d.regWrite = 1'($urandom_range(0, 1));
         d.resultSrc = 3'($urandom_range(0, 4)); d.memWrite = 1'($urandom_range(0, 1));
         d.branch = 1'($urandom_range(0, 1)); d.aluSrc = 1'($urandom_range(0, 1));
         d.jump = 2'($urandom_range(0, 2)); d.aluOp = 2'($urandom_range(0, 3));
         d.pc = $urandom; d.pcPlus4 = $urandom; d.rd1 = $urandom; d.rd2 = $urandom;
         d.imm = $urandom; d.rs1 = 5'($urandom_range(0, 3)); d.rs2 = 5'($urandom_range(0, 3));
         d.rd = 5'($urandom_range(0, 3)); d.funct3 = 3'($urandom_range(0, 7));
         d.csrAddr = 12'($urandom_range(0, 4095));
         st = ($urandom_range(0, 3) == 0);
         fl = ($urandom_range(0, 5) == 0);
         cycle(d, st, fl, lusModel(modelE, d), "b2b_random");
      end
   endtask

`ifdef ID_EX_BUBBLE_CNT_EN
   task automatic test_bubble_count();
      stageT lw, add;
      @(negedge clk) rst_n = 1'b0;
      @(negedge clk) rst_n = 1'b1;
      clearModel();
      lw  = mkInstr(3'b001, 1'b1, 1'b0, 5'd2, 5'd0, 5'd5, 32'h600);
      add = mkInstr(3'b000, 1'b1, 1'b0, 5'd5, 5'd1, 5'd6, 32'h604);
      for (int i = 0; i < 3; i++) cycle(add, 1'b0, 1'b1, 1'b0, "bc_flush");
      cycle(add, 1'b1, 1'b0, 1'b0, "bc_hold_no_count");
      cycle(lw, 1'b0, 1'b0, 1'b0, "bc_lw");
      cycle(add, 1'b0, 1'b0, 1'b1, "bc_load_use");
      total++;
      if (BubbleCntE !== 32'd4) begin
         bad++;
         $display("FAIL bc_total got=%0d want=4", BubbleCntE);
      end
   endtask
`endif

   initial begin
      rst_n = 1'b0; StallE = 1'b0; FlushE = 1'b0;
      applyD('0);
      clearModel();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      test_reset();
      test_pass_through();
      test_load_use();
      test_no_stall();
      test_flush_stall();
      test_back_to_back();
`ifdef ID_EX_BUBBLE_CNT_EN
      test_bubble_count();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
